// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with immediate extension, WB bypass, flush/stall and bubble counter.
module id_ex_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_stall,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [31:0]        i_pc_plus4,
  input  logic [DATA_W-1:0]  i_rd1,
  input  logic [DATA_W-1:0]  i_rd2,
  input  logic [15:0]        i_imm16,
  input  logic [1:0]         i_ext_sel,
  input  logic [REG_AW-1:0]  i_rs,
  input  logic [REG_AW-1:0]  i_rt,
  input  logic [REG_AW-1:0]  i_rd,
  input  logic               i_reg_write,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic               i_alu_src,
  input  logic               i_reg_dst,
  input  logic [ALUOP_W-1:0] i_alu_op,
  input  logic               i_wb_reg_write,
  input  logic [REG_AW-1:0]  i_wb_write_reg,
  input  logic [DATA_W-1:0]  i_wb_write_data,
  output logic               o_valid,
  output logic [31:0]        o_pc_plus4,
  output logic [DATA_W-1:0]  o_rd1,
  output logic [DATA_W-1:0]  o_rd2,
  output logic [DATA_W-1:0]  o_imm,
  output logic [REG_AW-1:0]  o_rs,
  output logic [REG_AW-1:0]  o_rt,
  output logic [REG_AW-1:0]  o_rd,
  output logic               o_reg_write,
  output logic               o_mem_read,
  output logic               o_mem_write,
  output logic               o_mem_to_reg,
  output logic               o_alu_src,
  output logic               o_reg_dst,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic [CNT_W-1:0]   o_bubble_count
);
  logic [DATA_W-1:0] w_imm;
  logic              w_byp1;
  logic              w_byp2;
  always_comb begin
    w_imm = i_ext_sel == 2'b01 ? {{(DATA_W-16){i_imm16[15]}}, i_imm16} :
            i_ext_sel == 2'b10 ? {i_imm16, {(DATA_W-16){1'b0}}} :
                                 {{(DATA_W-16){1'b0}}, i_imm16};
    w_byp1 = i_wb_reg_write && i_wb_write_reg != '0 && i_wb_write_reg == i_rs;
    w_byp2 = i_wb_reg_write && i_wb_write_reg != '0 && i_wb_write_reg == i_rt;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      o_valid      <= 1'b0;
      o_pc_plus4   <= '0;
      o_rd1        <= '0;
      o_rd2        <= '0;
      o_imm        <= '0;
      o_rs         <= '0;
      o_rt         <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_alu_src    <= 1'b0;
      o_reg_dst    <= 1'b0;
      o_alu_op     <= '0;
    end else if (!i_stall) begin
      o_valid      <= i_valid;
      o_pc_plus4   <= i_pc_plus4;
      o_rd1        <= w_byp1 ? i_wb_write_data : i_rd1;
      o_rd2        <= w_byp2 ? i_wb_write_data : i_rd2;
      o_imm        <= w_imm;
      o_rs         <= i_rs;
      o_rt         <= i_rt;
      o_rd         <= i_rd;
      o_reg_write  <= i_valid & i_reg_write;
      o_mem_read   <= i_valid & i_mem_read;
      o_mem_write  <= i_valid & i_mem_write;
      o_mem_to_reg <= i_valid & i_mem_to_reg;
      o_alu_src    <= i_valid & i_alu_src;
      o_reg_dst    <= i_valid & i_reg_dst;
      o_alu_op     <= i_valid ? i_alu_op : '0;
    end
  end
  // Saturating: stops at all-ones instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) o_bubble_count <= '0;
    else if (i_flush) o_bubble_count <= o_bubble_count + CNT_W'(o_bubble_count != '1);
  end
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed vectors with a queue-based scoreboard checked by an independent monitor.
module tb_id_ex_stage_reg;
  typedef struct packed {
    logic        v;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw, m2r, as, rdst;
    logic [3:0]  op;
    logic [15:0] bc;
  } out_t;
  typedef struct { string name; out_t e; } item_t;

  logic clk = 0, rst_n = 0, stall = 0, flush = 0, valid = 0;
  logic [31:0] pc = 0, rd1 = 0, rd2 = 0, wb_data = 0;
  logic [15:0] imm16 = 0;
  logic [1:0] ext = 0;
  logic [4:0] rs = 0, rt = 0, rd = 0, wb_reg = 0;
  logic rw = 0, mr = 0, mw = 0, m2r = 0, as = 0, rdst = 0, wb_rw = 0;
  logic [3:0] op = 0;
  out_t act, e;
  item_t q[$];
  int vectors = 0, miscompares = 0;
  logic [15:0] bc_m;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid(valid),
    .i_pc_plus4(pc), .i_rd1(rd1), .i_rd2(rd2), .i_imm16(imm16), .i_ext_sel(ext),
    .i_rs(rs), .i_rt(rt), .i_rd(rd), .i_reg_write(rw), .i_mem_read(mr), .i_mem_write(mw),
    .i_mem_to_reg(m2r), .i_alu_src(as), .i_reg_dst(rdst), .i_alu_op(op),
    .i_wb_reg_write(wb_rw), .i_wb_write_reg(wb_reg), .i_wb_write_data(wb_data),
    .o_valid(act.v), .o_pc_plus4(act.pc), .o_rd1(act.rd1), .o_rd2(act.rd2), .o_imm(act.imm),
    .o_rs(act.rs), .o_rt(act.rt), .o_rd(act.rd), .o_reg_write(act.rw), .o_mem_read(act.mr),
    .o_mem_write(act.mw), .o_mem_to_reg(act.m2r), .o_alu_src(act.as), .o_reg_dst(act.rdst),
    .o_alu_op(act.op), .o_bubble_count(act.bc)
  );

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      item_t it;
      it = q.pop_front();
      vectors++;
      if (act !== it.e) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.e);
      end
    end
  end

  task automatic step(input string name, input out_t exp);
    q.push_back('{name, exp});
    @(negedge clk);
  endtask

  task automatic clr_in();
    {stall, flush, valid, pc, rd1, rd2, imm16, ext, rs, rt, rd} = '0;
    {rw, mr, mw, m2r, as, rdst, op, wb_rw, wb_reg, wb_data} = '0;
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      {pc, rd1, rd2, wb_data} = {$urandom, $urandom, $urandom, $urandom};
      {imm16, ext, rs, rt, rd, op} = 37'($urandom);
      {valid, rw, mr, mw, m2r, as, rdst, stall, flush, wb_rw} = 10'($urandom);
      rst_n = 0;
      step("reset", '0);
    end
    rst_n = 1; clr_in(); valid = 1; op = 4'h5;
    e = '0; e.v = 1; e.op = 4'h5;
    step("release_load", e);
    imm16 = 16'h8001;
    ext = 2'b00; e.imm = 32'h0000_8001; step("ext_zero", e);
    ext = 2'b01; e.imm = 32'hFFFF_8001; step("ext_sign_neg", e);
    ext = 2'b10; e.imm = 32'h8001_0000; step("ext_upper", e);
    ext = 2'b11; e.imm = 32'h0000_8001; step("ext_11_as_zero", e);
    imm16 = 16'h7FFF; ext = 2'b01; e.imm = 32'h0000_7FFF; step("ext_sign_pos", e);
    imm16 = 0; ext = 0; rd1 = 32'hDEADBEEF; rw = 1; pc = 32'h0000_0104;
    e.imm = 0; e.rd1 = 32'hDEADBEEF; e.rw = 1; e.pc = 32'h0000_0104;
    step("load_deadbeef", e);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      rd1 = 32'h1234_0000 + i; rw = 0; imm16 = 16'hFFFF; ext = 1; rs = 5'(i + 3); valid = i[0];
      step("stall_hold", e);
    end
    flush = 1; rd1 = 32'h5555_5555; valid = 1; rw = 1;
    e = '0; e.bc = 16'd1;
    step("stall_flush", e);
    clr_in(); valid = 1; rs = 7; rt = 7; rd1 = 32'h1111_1111; rd2 = 32'h1111_1111;
    wb_rw = 1; wb_reg = 7; wb_data = 32'h2222_2222;
    e.v = 1; e.rs = 7; e.rt = 7; e.rd1 = 32'h2222_2222; e.rd2 = 32'h2222_2222;
    step("bypass_both", e);
    wb_reg = 0; rs = 0;
    e.rs = 0; e.rd1 = 32'h1111_1111; e.rd2 = 32'h1111_1111;
    step("bypass_r0_never", e);
    rs = 7; wb_reg = 7; wb_rw = 0;
    e.rs = 7;
    step("bypass_no_wb_write", e);
    wb_rw = 1; rt = 3; rd2 = 32'h3333_3333;
    e.rt = 3; e.rd1 = 32'h2222_2222; e.rd2 = 32'h3333_3333;
    step("bypass_rs_only", e);
    clr_in(); rw = 1; mw = 1; mr = 1; m2r = 1; as = 1; rdst = 1; op = 4'hF;
    rd1 = 32'h5; rd = 9; pc = 32'h200;
    e = '0; e.bc = 16'd1; e.rd1 = 32'h5; e.rd = 9; e.pc = 32'h200;
    step("invalid_load", e);
    clr_in(); flush = 1; valid = 1; rw = 1; op = 4'h3;
    bc_m = 16'd1;
    for (int i = 0; i < 65538; i++) begin
      bc_m = (bc_m == 16'hFFFF) ? bc_m : bc_m + 16'd1;
      e = '0; e.bc = bc_m;
      step("flush_saturate", e);
    end
    flush = 0; stall = 1;
    step("stall_holds_count", e);
    stall = 0; flush = 1; rst_n = 0;
    step("reset_clears_count", '0);
    for (int i = 0; i < 3 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d vectors left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Pipeline register between Decode and Execute in the five-stage CPU.
- Captures decoded operands, register specifiers and control bits each cycle.
- Performs the 16-to-32 immediate extension (zero, sign or upper) at capture time, so EX receives a registered 32-bit immediate.
- Supports stall (hold), flush (bubble insertion), WB-to-ID same-cycle bypass, and a saturating bubble counter for performance debug.

Parameters:
- DATA_W, 32, operand and immediate output width.
- REG_AW, 5, register specifier width.
- ALUOP_W, 4, ALU operation code width.
- CNT_W, 16, bubble counter width.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous reset, active-low.
- Stall  in  1  hold all outputs.
- Flush  in  1  load a bubble.
- ValidIn  in  1  ID holds a real instruction.
- PCPlus4In  in  32  PC+4 from ID.
- RD1In  in  32  register file read port 1.
- RD2In  in  32  register file read port 2.
- Imm16In  in  16  raw instruction immediate.
- ExtSel  in  2  00 zero-extend, 01 sign-extend, 10 upper ({imm,16'b0}), 11 treated as 00.
- RsIn, RtIn, RdIn  in  5 each  register specifiers.
- RegWriteIn, MemReadIn, MemWriteIn, MemtoRegIn, ALUSrcIn, RegDstIn  in  1 each  control bits.
- ALUOpIn  in  4  ALU operation.
- WBRegWrite  in  1  WB stage writing register file this cycle.
- WBWriteReg  in  5  WB destination register.
- WBWriteData  in  32  WB write data.
- ValidOut, PCPlus4Out, RD1Out, RD2Out, ImmOut(32), RsOut, RtOut, RdOut, RegWriteOut, MemReadOut, MemWriteOut, MemtoRegOut, ALUSrcOut, RegDstOut, ALUOpOut  out  as inputs  registered copies.
- BubbleCount  out  16  saturating count of flush-inserted bubbles.

Behaviour:
- All outputs are registered and update only on the rising edge of Clk. Latency from ID inputs to outputs is 1 cycle. No combinational path from input to output.
- Priority per edge is: Rst==0 > Flush > Stall > load.
- Reset clears every output to 0, including ValidOut, ImmOut, all control bits and BubbleCount. Reset mid-stall or mid-flush still clears everything.
- Flush:
  - Loads ValidOut=0 and clears RegWriteOut, MemReadOut, MemWriteOut, MemtoRegOut, ALUSrcOut, RegDstOut and ALUOpOut.
  - Data and specifier outputs are also cleared to 0.
  - Flush and Stall asserted together gives Flush behaviour.
  - BubbleCount increments by 1 per flush cycle and saturates at 0xFFFF with no wrap.
- Stall: every output holds its value, including BubbleCount.
- Load: all fields are captured from inputs, with ValidOut=ValidIn. If ValidIn=0, control bits are captured as 0, regardless of their inputs.
- Immediate extension, captured into ImmOut:
  - ExtSel 00: {16'h0000, Imm16In}.
  - ExtSel 01: {{16{Imm16In[15]}}, Imm16In}.
  - ExtSel 10: {Imm16In, 16'h0000}.
  - ExtSel 11: same as 00.
- WB bypass, applied on load only:
  - If WBRegWrite=1, WBWriteReg!=0 and WBWriteReg==RsIn, RD1Out captures WBWriteData instead of RD1In.
  - Same rule for RtIn and RD2Out, evaluated independently; both bypass if Rs==Rt==WBWriteReg.
  - Register 0 is never bypassed.
  - A held stall does not re-evaluate the bypass. The stall controller must keep the stall asserted only while WB is not writing a needed operand.

Test Plan:
- Reset: Rst=0 for 2 cycles with random inputs -> every output reads 0. Release Rst and load ValidIn=1, ALUOpIn=4'h5 -> one cycle later ValidOut=1, ALUOpOut=5.
- Extension: Imm16In=16'h8001 with ExtSel=00/01/10/11 -> ImmOut = 0x00008001 / 0xFFFF8001 / 0x80010000 / 0x00008001. Also Imm16In=16'h7FFF with ExtSel=01 -> 0x00007FFF.
- Stall then flush: load RD1In=0xDEADBEEF, then Stall=1 for 3 cycles while inputs change -> RD1Out stays 0xDEADBEEF. Then Stall=1 and Flush=1 together -> ValidOut=0, RegWriteOut=0, BubbleCount=1.
- Bypass: RsIn=RtIn=5'd7, RD1In=RD2In=0x11111111, WBRegWrite=1, WBWriteReg=7, WBWriteData=0x22222222 -> RD1Out=RD2Out=0x22222222. Repeat with WBWriteReg=0 and RsIn=0 -> RD1Out=0x11111111.
- Invalid load: ValidIn=0 with RegWriteIn=MemWriteIn=1 -> ValidOut=0, RegWriteOut=0, MemWriteOut=0.
- Saturation: force 65536 consecutive flush cycles -> BubbleCount reaches 0xFFFF and stays there. A following reset -> BubbleCount=0.
